// File: rtl/hex_char_rotator_if.sv
// Handshake-free control/data bundle between the marquee controller and the
// character rotator. clk and reset stay as plain ports on the rotator.
interface hex_char_rotator_if #(
    parameter int NUM_DIGITS = 8,
    parameter int CHAR_W     = 3
);
    localparam int W     = NUM_DIGITS * CHAR_W;
    localparam int POS_W = $clog2(NUM_DIGITS);

    logic             run;
    logic             dir;
    logic             step;
    logic             load;
    logic [W-1:0]     load_chars;
    logic [W-1:0]     chars;
    logic [POS_W-1:0] pos;
    logic             tick;

    // controller side: drives the controls, observes the display word
    modport master (
        output run, dir, step, load, load_chars,
        input  chars, pos, tick
    );

    // rotator side
    modport slave (
        input  run, dir, step, load, load_chars,
        output chars, pos, tick
    );
endinterface

// File: rtl/hex_char_rotator.sv
// Holds one character code per display digit and rotates the whole word one
// digit left (toward HEX7) or right, on a prescaled automatic tick or on the
// rising edge of a manual step. A parallel load overrides everything.
module hex_char_rotator #(
    parameter int          NUM_DIGITS    = 8,
    parameter int          CHAR_W        = 3,
    parameter int          TICK_DIV      = 50_000_000,
    parameter logic [23:0] RESET_PATTERN = 24'hFF8293
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    hex_char_rotator_if.slave bus
);
    localparam int W     = NUM_DIGITS * CHAR_W;
    localparam int POS_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(TICK_DIV);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_DIGITS - 1);
    localparam logic [W-1:0]     RST_WORD = W'(RESET_PATTERN);

    logic [W-1:0]     chars_q, chars_d;
    logic [POS_W-1:0] pos_q,   pos_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             tick_q,  tick_d;
    logic             step_q;

    logic at_wrap;
    logic auto_rot;
    logic man_rot;
    logic rot;
    logic [W-1:0] rot_left;
    logic [W-1:0] rot_right;

    assign at_wrap  = (cnt_q == CNT_LAST);
    assign auto_rot = bus.run & ~bus.load & at_wrap;
    assign man_rot  = bus.step & ~step_q & ~bus.load;
    // an auto and a manual trigger on the same edge still give one rotation
    assign rot      = auto_rot | man_rot;

    // left: digit k takes digit k-1, digit 0 takes the top digit
    assign rot_left  = {chars_q[W-CHAR_W-1:0], chars_q[W-1:W-CHAR_W]};
    // right: digit k takes digit k+1, the top digit takes digit 0
    assign rot_right = {chars_q[CHAR_W-1:0], chars_q[W-1:CHAR_W]};

    // next-state selection: load beats rotation, rotation beats hold
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch
        chars_d = chars_q;
        pos_d   = pos_q;
        cnt_d   = cnt_q;
        tick_d  = 1'b0;
        if (bus.load) begin
            chars_d = bus.load_chars;
            pos_d   = '0;
            cnt_d   = '0;
        end else begin
            tick_d = auto_rot;
            if (bus.run) begin
                cnt_d = at_wrap ? '0 : cnt_q + 1'b1;
            end
            if (rot) begin
                if (bus.dir) begin
                    chars_d = rot_right;
                    pos_d   = (pos_q == '0) ? POS_LAST : pos_q - 1'b1;
                end else begin
                    chars_d = rot_left;
                    pos_d   = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
                end
            end
        end
    end

    // state registers; reset is asynchronous and drops any rotation in progress
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            chars_q <= RST_WORD;
            pos_q   <= '0;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values
            chars_q <= chars_d;
            pos_q   <= pos_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            step_q  <= bus.step;
        end
    end

    assign bus.chars = chars_q;
    assign bus.pos   = pos_q;
    assign bus.tick  = tick_q;
endmodule

// File: tb/tb_hex_char_rotator.sv
// Scoreboard bench for hex_char_rotator with a short prescaler. The stimulus
// process predicts each cycle's outputs from a digit-array model and queues
// them; the monitor pops and compares after every rising edge.
module tb_hex_char_rotator;
    localparam int N  = 8;
    localparam int CW = 3;
    localparam int TD = 4;

    typedef struct {
        logic [23:0] chars;
        logic [2:0]  pos;
        logic        tick;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    hex_char_rotator_if #(.NUM_DIGITS(N), .CHAR_W(CW)) bus ();

    hex_char_rotator #(
        .NUM_DIGITS(N), .CHAR_W(CW), .TICK_DIV(TD), .RESET_PATTERN(24'hFF8293)
    ) dut (
        .CLOCK_50(clk),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int ticks_seen = 0;
    exp_t sb[$];

    // reference model: digits as an array, position and prescaler as integers
    int m_dig[N];
    int m_pos;
    int m_cnt;
    bit m_stepq;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [23:0] pack_model();
        logic [23:0] w = '0;
        for (int k = 0; k < N; k++) w[k*CW +: CW] = 3'(m_dig[k]);
        return w;
    endfunction

    task automatic model_reset();
        logic [23:0] rp = 24'hFF8293;
        for (int k = 0; k < N; k++) m_dig[k] = int'(rp[k*CW +: CW]);
        m_pos = 0;
        m_cnt = 0;
        m_stepq = 0;
    endtask

    // drive one cycle of inputs, advance the model past the coming edge, queue the prediction
    task automatic drive(input bit run, input bit dir, input bit step, input bit load,
                         input logic [23:0] lc);
        exp_t e;
        int tmp[N];
        bit a, m;
        @(negedge clk);
        bus.run = run; bus.dir = dir; bus.step = step; bus.load = load; bus.load_chars = lc;
        e.tick = 1'b0;
        if (load) begin
            for (int k = 0; k < N; k++) m_dig[k] = int'(lc[k*CW +: CW]);
            m_pos = 0;
            m_cnt = 0;
        end else begin
            a = run && (m_cnt == TD - 1);
            m = step && !m_stepq;
            if (run) m_cnt = (m_cnt + 1) % TD;
            e.tick = a;
            if (a || m) begin
                for (int k = 0; k < N; k++)
                    tmp[k] = dir ? m_dig[(k + 1) % N] : m_dig[(k + N - 1) % N];
                m_dig = tmp;
                m_pos = dir ? (m_pos + N - 1) % N : (m_pos + 1) % N;
            end
        end
        m_stepq = step;
        e.chars = pack_model();
        e.pos = 3'(m_pos);
        sb.push_back(e);
    endtask

    // async reset mid-cycle, checked before any clock edge; leaves inputs idle
    task automatic apply_reset(input string tag);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check({tag, "_rst_chars"}, 32'(bus.chars), 32'h00FF8293);
        check({tag, "_rst_pos"},   32'(bus.pos),   32'd0);
        check({tag, "_rst_tick"},  32'(bus.tick),  32'd0);
        sb.delete();
        model_reset();
        bus.run = 0; bus.dir = 0; bus.step = 0; bus.load = 0; bus.load_chars = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drain(input string tag);
        @(posedge clk);
        #2;
        check({tag, "_drained"}, 32'(sb.size()), 32'd0);
    endtask

    // monitor: one prediction per cycle, compared after the edge settles
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (bus.tick === 1'b1) ticks_seen++;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("sb_chars", 32'(bus.chars), 32'(e.chars));
                check("sb_pos",   32'(bus.pos),   32'(e.pos));
                check("sb_tick",  32'(bus.tick),  32'(e.tick));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        bus.run = 0; bus.dir = 0; bus.step = 0; bus.load = 0; bus.load_chars = '0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // run for two clocks then reset asynchronously
        drive(1, 0, 0, 0, '0);
        drive(1, 0, 0, 0, '0);
        apply_reset("t1");

        // one automatic left rotation
        repeat (TD) drive(1, 0, 0, 0, '0);
        drain("t2");
        check("t2_chars", 32'(bus.chars), 32'h00FC149F);
        check("t2_pos",   32'(bus.pos),   32'd1);

        // one automatic right rotation
        apply_reset("t3");
        repeat (TD) drive(1, 1, 0, 0, '0);
        drain("t3");
        check("t3_chars", 32'(bus.chars), 32'h007FF052);
        check("t3_pos",   32'(bus.pos),   32'd7);

        // a full lap returns to the reset word
        apply_reset("t4");
        ticks_seen = 0;
        repeat (N * TD) drive(1, 0, 0, 0, '0);
        drain("t4");
        check("t4_ticks", 32'(ticks_seen), 32'd8);
        check("t4_chars", 32'(bus.chars), 32'h00FF8293);
        check("t4_pos",   32'(bus.pos),   32'd0);

        // load on the wrap edge suppresses the tick; next tick 4 clocks later
        apply_reset("t5");
        repeat (TD - 1) drive(1, 0, 0, 0, '0);
        drive(1, 0, 0, 1, 24'h000000);
        drain("t5a");
        check("t5_chars", 32'(bus.chars), 32'd0);
        check("t5_tick",  32'(bus.tick),  32'd0);
        ticks_seen = 0;
        repeat (TD - 1) drive(1, 0, 0, 0, '0);
        drain("t5b");
        check("t5_no_early_tick", 32'(ticks_seen), 32'd0);
        drive(1, 0, 0, 0, '0);
        drain("t5c");
        check("t5_tick_on_4th", 32'(bus.tick), 32'd1);

        // held step rotates once; a fresh edge rotates again
        apply_reset("t6");
        repeat (10) drive(0, 0, 1, 0, '0);
        drive(0, 0, 0, 0, '0);
        drive(0, 0, 1, 0, '0);
        drain("t6a");
        check("t6_two_steps", 32'(bus.pos), 32'd2);

        // step edge on the auto edge: still one rotation
        apply_reset("t6b");
        repeat (TD - 1) drive(1, 0, 0, 0, '0);
        drive(1, 0, 1, 0, '0);
        drain("t6b");
        check("t6_coincide_pos",  32'(bus.pos),  32'd1);
        check("t6_coincide_tick", 32'(bus.tick), 32'd1);

        // randomized mix of run/dir/step/load against the model
        apply_reset("rnd");
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                  $urandom_range(0, 19) == 0, 24'($urandom));
        end
        drain("rnd");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
